// File: rtl/validador_de_jogada.sv
// Shot validator: debounces the confirm button, latches the switch coordinate
// on an accepted press, classifies it against the shot history and the map,
// and emits one single-cycle result pulse per press.
module validador_de_jogada #(
  parameter int unsigned ESTAVEL = 4
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       amostra,
  input  logic       enable,
  input  logic       btn,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic       acerto,
  output logic       agua,
  output logic       repetida,
  output logic       invalida,
  output logic [2:0] coluna_out,
  output logic [2:0] linha_out,
  output logic [6:0] tiros0,
  output logic [6:0] tiros1,
  output logic [6:0] tiros2,
  output logic [6:0] tiros3,
  output logic [6:0] tiros4,
  output logic [5:0] num_tiros,
  output logic [5:0] num_acertos
);

  localparam int unsigned CNT_W = $clog2(ESTAVEL + 1);
  localparam int unsigned IDX_W = 6;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    AVALIA = 2'd1,
    SOLTAR = 2'd2
  } estado_t;

  estado_t          estado;
  logic [1:0]       sync;
  logic             nivel;
  logic             nivel_q;
  logic [CNT_W-1:0] cnt;
  logic             en_q;
  logic [34:0]      hist;
  logic [34:0]      mapa_flat;
  logic [IDX_W-1:0] idx;
  logic             queda;
  logic             en_sobe;
  logic             fora;

  // Flattened map/history, cell (C,L) lives at bit C*7+L
  assign mapa_flat = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign idx       = IDX_W'(coluna_out) * IDX_W'(7) + IDX_W'(linha_out);
  assign fora      = (coluna_out > 3'd4) || (linha_out > 3'd6);
  assign queda     = nivel_q & ~nivel;
  assign en_sobe   = enable & ~en_q;

  assign tiros0 = hist[6:0];
  assign tiros1 = hist[13:7];
  assign tiros2 = hist[20:14];
  assign tiros3 = hist[27:21];
  assign tiros4 = hist[34:28];

  // Button synchroniser and debouncer; accepted level idles high (released)
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= 2'b11;
      nivel   <= 1'b1;
      nivel_q <= 1'b1;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], btn};
      nivel_q <= nivel;
      if (sync[1] == nivel) begin
        cnt <= '0;
      end else if (amostra) begin
        if (cnt == CNT_W'(ESTAVEL - 1)) begin
          nivel <= ~nivel;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Press FSM, classification, history and counters
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      en_q        <= 1'b0;
      acerto      <= 1'b0;
      agua        <= 1'b0;
      repetida    <= 1'b0;
      invalida    <= 1'b0;
      coluna_out  <= '0;
      linha_out   <= '0;
      hist        <= '0;
      num_tiros   <= '0;
      num_acertos <= '0;
    end else begin
      en_q     <= enable;
      acerto   <= 1'b0;
      agua     <= 1'b0;
      repetida <= 1'b0;
      invalida <= 1'b0;
      if (!enable) begin
        estado <= OCIOSO;
      end else begin
        // A new attack phase starts with a clean board
        if (en_sobe) begin
          hist        <= '0;
          num_tiros   <= '0;
          num_acertos <= '0;
        end
        case (estado)
          OCIOSO: begin
            if (queda && !en_sobe) begin
              coluna_out <= coordColuna;
              linha_out  <= coordLinha;
              estado     <= AVALIA;
            end
          end
          AVALIA: begin
            estado <= SOLTAR;
            if (fora) begin
              invalida <= 1'b1;
            end else if (hist[idx]) begin
              repetida <= 1'b1;
            end else begin
              hist[idx] <= 1'b1;
              num_tiros <= num_tiros + 6'd1;
              if (mapa_flat[idx]) begin
                acerto      <= 1'b1;
                num_acertos <= num_acertos + 6'd1;
              end else begin
                agua <= 1'b1;
              end
            end
          end
          SOLTAR: begin
            if (nivel) estado <= OCIOSO;
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_validador_de_jogada.sv
// Bench for validador_de_jogada: table vectors, hand-written debounce/enable/
// reset sequences and a randomized run against a cell-array reference model.
module tb_validador_de_jogada;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       amostra;
  logic       enable;
  logic       btn;
  logic [2:0] coordColuna, coordLinha;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic       acerto, agua, repetida, invalida;
  logic [2:0] coluna_out, linha_out;
  logic [6:0] tiros0, tiros1, tiros2, tiros3, tiros4;
  logic [5:0] num_tiros, num_acertos;

  localparam int K_NONE = 0, K_ACERTO = 1, K_AGUA = 2, K_REP = 3, K_INV = 4;

  validador_de_jogada #(.ESTAVEL(4)) dut (
    .clock_in(clk), .reset_n(reset_n), .amostra(amostra), .enable(enable),
    .btn(btn), .coordColuna(coordColuna), .coordLinha(coordLinha),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .acerto(acerto), .agua(agua), .repetida(repetida), .invalida(invalida),
    .coluna_out(coluna_out), .linha_out(linha_out),
    .tiros0(tiros0), .tiros1(tiros1), .tiros2(tiros2), .tiros3(tiros3),
    .tiros4(tiros4), .num_tiros(num_tiros), .num_acertos(num_acertos)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain board of shot/ship flags and two counters
  bit ship [5][7];
  bit shot [5][7];
  int m_tiros, m_acertos;

  // Monitor state
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int last_kind = K_NONE;
  int multi = 0;

  // Sample-tick control
  bit auto_tick = 1'b1;
  int man_req = 0;
  int man_done = 0;
  int tick_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Records every result pulse, just after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset_n) begin
        int n;
        n = int'(acerto) + int'(agua) + int'(repetida) + int'(invalida);
        if (n != 0) begin
          pulse_cnt++;
          pulse_cyc = cyc;
          if (acerto) last_kind = K_ACERTO;
          else if (agua) last_kind = K_AGUA;
          else if (repetida) last_kind = K_REP;
          else last_kind = K_INV;
          if (n > 1) multi++;
        end
      end
    end
  end

  // Divider stand-in: one tick every 4 cycles, or single manual ticks
  initial begin
    int div;
    div = 0;
    amostra = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (auto_tick) begin
        amostra = (div == 0);
        div = (div + 1) % 4;
      end else if (man_done < man_req && !amostra) begin
        amostra = 1'b1;
        man_done++;
        tick_cyc = cyc;
      end else begin
        amostra = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1);
  end

  task automatic set_map_col(input int c, input logic [6:0] v);
    for (int r = 0; r < 7; r++) ship[c][r] = v[r];
    case (c)
      0: mapa0 = v;
      1: mapa1 = v;
      2: mapa2 = v;
      3: mapa3 = v;
      default: mapa4 = v;
    endcase
  endtask

  task automatic model_clear();
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++) shot[c][r] = 1'b0;
    m_tiros = 0;
    m_acertos = 0;
  endtask

  function automatic int model_shot(input int c, input int r);
    if (c > 4 || r > 6) return K_INV;
    if (shot[c][r]) return K_REP;
    shot[c][r] = 1'b1;
    m_tiros++;
    if (ship[c][r]) begin
      m_acertos++;
      return K_ACERTO;
    end
    return K_AGUA;
  endfunction

  function automatic int dut_tiros(input int c);
    case (c)
      0: return int'(tiros0);
      1: return int'(tiros1);
      2: return int'(tiros2);
      3: return int'(tiros3);
      default: return int'(tiros4);
    endcase
  endfunction

  function automatic int exp_tiros(input int c);
    int v;
    v = 0;
    for (int r = 0; r < 7; r++) if (shot[c][r]) v += (1 << r);
    return v;
  endfunction

  task automatic check_state(input string name);
    check({name, " num_tiros"}, int'(num_tiros), m_tiros);
    check({name, " num_acertos"}, int'(num_acertos), m_acertos);
    for (int c = 0; c < 5; c++)
      check($sformatf("%s tiros%0d", name, c), dut_tiros(c), exp_tiros(c));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, " pulses"}, int'({acerto, agua, repetida, invalida}), 0);
    check({name, " coluna_out"}, int'(coluna_out), 0);
    check({name, " linha_out"}, int'(linha_out), 0);
    check({name, " num_tiros"}, int'(num_tiros), 0);
    check({name, " num_acertos"}, int'(num_acertos), 0);
    for (int c = 0; c < 5; c++)
      check($sformatf("%s tiros%0d", name, c), dut_tiros(c), 0);
  endtask

  // Full press: hold until the result, scramble switches, hold, release
  task automatic do_press(input int col, input int row, input int exp_kind,
                          input string name);
    int base;
    coordColuna = 3'(col);
    coordLinha  = 3'(row);
    base = pulse_cnt;
    btn = 1'b0;
    for (int i = 0; i < 200 && pulse_cnt == base; i++) @(negedge clk);
    coordColuna = 3'($urandom);
    coordLinha  = 3'($urandom);
    wait_cycles(30);
    btn = 1'b1;
    wait_cycles(40);
    check({name, " pulse count"}, pulse_cnt - base, 1);
    check({name, " kind"}, last_kind, exp_kind);
    check({name, " coluna_out"}, int'(coluna_out), col);
    check({name, " linha_out"}, int'(linha_out), row);
    check_state(name);
  endtask

  typedef struct {
    int    col;
    int    row;
    int    kind;
    string name;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int base;
    vecs[0] = '{2, 3, K_ACERTO, "hit_c2r3"};
    vecs[1] = '{2, 3, K_REP,    "repeat_c2r3"};
    vecs[2] = '{0, 0, K_AGUA,   "miss_c0r0"};
    vecs[3] = '{5, 2, K_INV,    "bad_col5"};
    vecs[4] = '{1, 7, K_INV,    "bad_row7"};

    reset_n = 1'b0;
    enable = 1'b0;
    btn = 1'b1;
    coordColuna = '0;
    coordLinha = '0;
    for (int c = 0; c < 5; c++) set_map_col(c, 7'b0);
    model_clear();
    wait_cycles(5);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    wait_cycles(2);
    enable = 1'b1;
    wait_cycles(5);

    // Table vectors
    set_map_col(2, 7'b0001000);
    for (int i = 0; i < 5; i++) begin
      int k;
      k = model_shot(vecs[i].col, vecs[i].row);
      do_press(vecs[i].col, vecs[i].row, vecs[i].kind, vecs[i].name);
      check({vecs[i].name, " model agrees"}, k, vecs[i].kind);
    end

    // Glitch: only 3 stable ticks, then released
    auto_tick = 1'b0;
    wait_cycles(5);
    coordColuna = 3'd4;
    coordLinha = 3'd6;
    base = pulse_cnt;
    btn = 1'b0;
    wait_cycles(3);
    man_req += 3;
    wait_cycles(20);
    btn = 1'b1;
    wait_cycles(20);
    check("glitch no pulse", pulse_cnt - base, 0);

    // 4 ticks: pulse two cycles after the accepting edge, which itself is one
    // edge after the tick is driven
    btn = 1'b0;
    wait_cycles(3);
    man_req += 4;
    wait_cycles(20);
    check("debounce pulse count", pulse_cnt - base, 1);
    check("debounce latency", pulse_cyc - tick_cyc, 3);
    check("debounce kind", last_kind, model_shot(4, 6));
    btn = 1'b1;
    wait_cycles(3);
    man_req += 4;
    wait_cycles(20);
    auto_tick = 1'b1;
    check_state("after debounce");

    // Enable off/on with the button held across the edge
    enable = 1'b0;
    wait_cycles(5);
    base = pulse_cnt;
    coordColuna = 3'd3;
    coordLinha = 3'd3;
    btn = 1'b0;
    wait_cycles(40);
    check("disabled no pulse", pulse_cnt - base, 0);
    check("disabled keeps num_tiros", int'(num_tiros), m_tiros);
    enable = 1'b1;
    model_clear();
    wait_cycles(2);
    check_state("enable rise clear");
    wait_cycles(40);
    check("held across enable no pulse", pulse_cnt - base, 0);
    btn = 1'b1;
    wait_cycles(40);
    check("release after enable no pulse", pulse_cnt - base, 0);
    do_press(3, 3, model_shot(3, 3), "after enable");

    // Reset while the FSM waits for release
    coordColuna = 3'd1;
    coordLinha = 3'd1;
    base = pulse_cnt;
    btn = 1'b0;
    for (int i = 0; i < 200 && pulse_cnt == base; i++) @(negedge clk);
    wait_cycles(5);
    reset_n = 1'b0;
    wait_cycles(2);
    check_zero_outputs("reset mid-press");
    btn = 1'b1;
    wait_cycles(2);
    reset_n = 1'b1;
    model_clear();
    base = pulse_cnt;
    wait_cycles(40);
    check("after reset no pulse", pulse_cnt - base, 0);
    do_press(1, 1, model_shot(1, 1), "after reset");

    // Randomized presses against the model
    for (int n = 0; n < 30; n++) begin
      int c, r;
      if (n % 8 == 0)
        for (int k = 0; k < 5; k++) set_map_col(k, 7'($urandom));
      c = int'($urandom_range(5, 0));
      r = int'($urandom_range(7, 0));
      do_press(c, r, model_shot(c, r), $sformatf("rand%0d", n));
    end

    check("mutual exclusion", multi, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
